// File: rtl/usrt_pkg.sv
// ----------------------------------------------------------------------------
// usrt_pkg
// Shared types and helpers for the USRT transmit arbiter.
//   usrt_state_e  : arbiter FSM states (S_IDLE, S_LOAD, S_BUSY, S_GAP)
//   USRT_BYTE_W   : width of one serialized byte
//   USRT_MAX_REQ  : largest supported requester count
//   USRT_IDX_W    : index width covering USRT_MAX_REQ requesters
//   rr_next()     : round-robin search starting after the last grant
// ----------------------------------------------------------------------------
package usrt_pkg;

    localparam int USRT_BYTE_W  = 8;
    localparam int USRT_MAX_REQ = 8;
    localparam int USRT_IDX_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BUSY = 2'd2,
        S_GAP  = 2'd3
    } usrt_state_e;

    // First set bit of req searching from ptr+1 upward, wrapping modulo num.
    // num is the real requester count, so the wrap is correct for
    // non-power-of-two counts. Returns ptr when no bit is set.
    function automatic logic [USRT_IDX_W-1:0] rr_next(
        input logic [USRT_MAX_REQ-1:0] req,
        input logic [USRT_IDX_W-1:0]   ptr,
        input int                      num
    );
        logic [USRT_IDX_W-1:0] idx;
        logic                  found;
        int                    cand;
        idx   = ptr;
        found = 1'b0;
        for (int i = 1; i <= USRT_MAX_REQ; i++) begin
            // ptr < num and i <= num, so one subtraction completes the wrap
            cand = int'(ptr) + i;
            if (cand >= num) begin
                cand = cand - num;
            end
            if (!found && (i <= num) && req[cand]) begin
                idx   = USRT_IDX_W'(cand);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/usrt_rr_picker.sv
// ----------------------------------------------------------------------------
// usrt_rr_picker
// Combinational round-robin selector. Picks the first active request after
// the last-granted index, wrapping modulo NUM_REQ.
// Ports:
//   i_Req  in   NUM_REQ  level requests
//   ptr    in   PTR_W    index of the last granted requester
//   o_Sel  out  NUM_REQ  one-hot selection (all zero when no request)
//   o_Idx  out  PTR_W    index of the selected requester
// ----------------------------------------------------------------------------
module usrt_rr_picker
    import usrt_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] o_Sel,
    output logic [PTR_W-1:0]   o_Idx
);

    logic [USRT_MAX_REQ-1:0] req_ext;
    logic [USRT_IDX_W-1:0]   idx_full;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = i_Req;
        idx_full               = rr_next(req_ext, USRT_IDX_W'(ptr), NUM_REQ);
        o_Sel                  = '0;
        o_Idx                  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (idx_full == USRT_IDX_W'(k)) begin
                o_Sel[k] = |i_Req;
                o_Idx    = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/usrt_tx_arbiter.sv
// ----------------------------------------------------------------------------
// usrt_tx_arbiter
// Shares one txshift serializer between NUM_REQ byte sources. Grants in
// round-robin order, latches the granted byte, pulses the serializer enable,
// holds the byte until txshift reports completion, then enforces an
// inter-frame gap of GAP_CYCLES before arbitrating again.
//
// Optional feature: define USRT_ARB_TIMEOUT_EN to add a BUSY watchdog that
// gives up after TIMEOUT_CYCLES BUSY cycles without a completion.
//
// Ports:
//   i_Clk        in   1          system clock (txshift i_Pclk)
//   i_Rst        in   1          synchronous reset, active-high
//   i_Req        in   NUM_REQ    level request per source
//   i_Data       in   8*NUM_REQ  byte k on i_Data[8k+7:8k]
//   o_Grant      out  NUM_REQ    one-hot pulse: byte k captured
//   o_Done       out  NUM_REQ    one-hot pulse: byte k fully shifted out
//   o_Tx_Enable  out  1          start pulse to txshift i_Enable
//   o_Tx_Data    out  8          byte to txshift i_Data
//   i_Tx_Pready  in   1          txshift completion pulse
//   o_Busy       out  1          high in every state except IDLE
//   o_Timeout    out  1          watchdog pulse (constant 0 without macro)
// ----------------------------------------------------------------------------
module usrt_tx_arbiter
    import usrt_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [USRT_BYTE_W*NUM_REQ-1:0] i_Data,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic [NUM_REQ-1:0]             o_Done,
    output logic                           o_Tx_Enable,
    output logic [USRT_BYTE_W-1:0]         o_Tx_Data,
    input  logic                           i_Tx_Pready,
    output logic                           o_Busy,
    output logic                           o_Timeout
);

    localparam int PTR_W    = $clog2(NUM_REQ);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    usrt_state_e            state, state_n;
    logic [USRT_BYTE_W-1:0] r_Data, data_n;
    logic [PTR_W-1:0]       r_Ptr, ptr_n;
    logic [GAP_W-1:0]       r_Gap, gap_n;
    logic [NUM_REQ-1:0]     grant_n, done_n;
    logic                   en_n;

    logic [NUM_REQ-1:0]     sel;
    logic [PTR_W-1:0]       sel_idx;

`ifdef USRT_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] r_Tmo, tmo_cnt_n;
    logic             r_Timeout, tmo_n;
`endif

    usrt_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_Req (i_Req),
        .ptr   (r_Ptr),
        .o_Sel (sel),
        .o_Idx (sel_idx)
    );

    always_comb begin
        state_n = state;
        data_n  = r_Data;
        ptr_n   = r_Ptr;
        gap_n   = r_Gap;
        grant_n = '0;
        done_n  = '0;
        en_n    = 1'b0;
`ifdef USRT_ARB_TIMEOUT_EN
        tmo_cnt_n = r_Tmo;
        tmo_n     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (|i_Req) begin
                    data_n  = i_Data[int'(sel_idx)*USRT_BYTE_W +: USRT_BYTE_W];
                    ptr_n   = sel_idx;
                    grant_n = sel;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                // Enable is registered, so txshift sees it in the first BUSY cycle.
                en_n    = 1'b1;
                state_n = S_BUSY;
`ifdef USRT_ARB_TIMEOUT_EN
                tmo_cnt_n = '0;
`endif
            end
            S_BUSY: begin
                if (i_Tx_Pready) begin
                    done_n[r_Ptr] = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_n = S_GAP;
                        gap_n   = GAP_W'(GAP_LOAD);
                    end else begin
                        state_n = S_IDLE;
                    end
                end
`ifdef USRT_ARB_TIMEOUT_EN
                // A completion in the expiry cycle takes precedence.
                else if (r_Tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_n = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_n = S_GAP;
                        gap_n   = GAP_W'(GAP_LOAD);
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    tmo_cnt_n = r_Tmo + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (r_Gap == '0) begin
                    state_n = S_IDLE;
                end else begin
                    gap_n = r_Gap - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            r_Data      <= '0;
            r_Ptr       <= PTR_W'(NUM_REQ - 1);
            r_Gap       <= '0;
            o_Grant     <= '0;
            o_Done      <= '0;
            o_Tx_Enable <= 1'b0;
        end else begin
            state       <= state_n;
            r_Data      <= data_n;
            r_Ptr       <= ptr_n;
            r_Gap       <= gap_n;
            o_Grant     <= grant_n;
            o_Done      <= done_n;
            o_Tx_Enable <= en_n;
        end
    end

`ifdef USRT_ARB_TIMEOUT_EN
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Tmo     <= '0;
            r_Timeout <= 1'b0;
        end else begin
            r_Tmo     <= tmo_cnt_n;
            r_Timeout <= tmo_n;
        end
    end

    assign o_Timeout = r_Timeout;
`else
    assign o_Timeout = 1'b0;
`endif

    assign o_Tx_Data = r_Data;
    assign o_Busy    = (state != S_IDLE);

endmodule

// File: tb/tb_usrt_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_usrt_tx_arbiter
// Directed bench for usrt_tx_arbiter with NUM_REQ=4, GAP_CYCLES=2,
// TIMEOUT_CYCLES=16. The watchdog step runs only when USRT_ARB_TIMEOUT_EN
// is defined for the build.
// ----------------------------------------------------------------------------
module tb_usrt_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        pready;
    logic        busy;
    logic        timeout;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    logic [3:0] exp_g;
    logic       early;

    always #5 clk = ~clk;

    usrt_tx_arbiter #(
        .NUM_REQ        (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Req       (req),
        .i_Data      (data),
        .o_Grant     (grant),
        .o_Done      (done),
        .o_Tx_Enable (tx_en),
        .o_Tx_Data   (tx_data),
        .i_Tx_Pready (pready),
        .o_Busy      (busy),
        .o_Timeout   (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance until a grant appears, at most 20 cycles.
    task automatic wait_grant(output int c);
        c = 0;
        while (grant == 4'b0 && c < 20) begin
            tick();
            c++;
        end
    endtask

    // Called in the cycle a grant is visible; runs the frame to its done pulse.
    task automatic finish_frame(input logic [3:0] req_after, input logic [3:0] exp_done);
        req = req_after;
        tick();
        chk("ff_enable", {31'b0, tx_en}, 32'd1);
        chk("ff_grant_clear", {28'b0, grant}, 32'd0);
        tick();
        chk("ff_enable_clear", {31'b0, tx_en}, 32'd0);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("ff_done", {28'b0, done}, {28'b0, exp_done});
        chk("ff_timeout", {31'b0, timeout}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        req    = 4'b1111;
        data   = {8'h44, 8'h33, 8'h22, 8'h11};
        pready = 1'b0;

        // Step 1: reset with all requests high, then first grant to requester 0
        tick(); tick(); tick();
        chk("rst_grant",   {28'b0, grant},  32'd0);
        chk("rst_done",    {28'b0, done},   32'd0);
        chk("rst_enable",  {31'b0, tx_en},  32'd0);
        chk("rst_data",    {24'b0, tx_data}, 32'd0);
        chk("rst_busy",    {31'b0, busy},   32'd0);
        chk("rst_timeout", {31'b0, timeout}, 32'd0);
        rst = 1'b0;
        tick();
        chk("s1_grant", {28'b0, grant}, 32'b0001);
        chk("s1_data",  {24'b0, tx_data}, 32'h11);
        chk("s1_busy",  {31'b0, busy}, 32'd1);
        finish_frame(4'b0000, 4'b0001);
        tick(); tick();
        chk("s1_idle", {31'b0, busy}, 32'd0);

        // Step 2: single request 2 with A5, completion 10 cycles after enable
        data = {8'h44, 8'hA5, 8'h22, 8'h11};
        req  = 4'b0100;
        wait_grant(cyc);
        chk("s2_grant", {28'b0, grant}, 32'b0100);
        chk("s2_data",  {24'b0, tx_data}, 32'hA5);
        req = 4'b0000;
        tick();
        chk("s2_enable", {31'b0, tx_en}, 32'd1);
        for (int i = 0; i < 9; i++) tick();
        chk("s2_data_hold", {24'b0, tx_data}, 32'hA5);
        chk("s2_no_early_done", {28'b0, done}, 32'd0);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("s2_done", {28'b0, done}, 32'b0100);
        req = 4'b0001;
        wait_grant(cyc);
        chk("s2_gap_cycles", cyc, 32'd3);
        chk("s2_next_grant", {28'b0, grant}, 32'b0001);
        chk("s2_next_data",  {24'b0, tx_data}, 32'h11);
        finish_frame(4'b0000, 4'b0001);
        tick(); tick();

        // Step 4: Pready during LOAD is ignored
        req = 4'b1000;
        wait_grant(cyc);
        chk("s4_grant", {28'b0, grant}, 32'b1000);
        chk("s4_data",  {24'b0, tx_data}, 32'h44);
        pready = 1'b1;
        req    = 4'b0000;
        tick();
        pready = 1'b0;
        chk("s4_enable", {31'b0, tx_en}, 32'd1);
        chk("s4_busy",   {31'b0, busy}, 32'd1);
        chk("s4_no_done_load", {28'b0, done}, 32'd0);
        tick(); tick();
        chk("s4_still_busy", {31'b0, busy}, 32'd1);
        chk("s4_no_done_wait", {28'b0, done}, 32'd0);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("s4_done", {28'b0, done}, 32'b1000);
        tick();
        chk("s4_done_single", {28'b0, done}, 32'd0);
        tick();
        chk("s4_idle", {31'b0, busy}, 32'd0);

        // Step 6: reset during BUSY aborts without a done pulse
        req = 4'b0010;
        wait_grant(cyc);
        chk("s6_grant", {28'b0, grant}, 32'b0010);
        req = 4'b0000;
        tick(); tick();
        chk("s6_busy_before", {31'b0, busy}, 32'd1);
        rst    = 1'b1;
        pready = 1'b1;
        tick();
        chk("s6_busy",   {31'b0, busy}, 32'd0);
        chk("s6_done",   {28'b0, done}, 32'd0);
        chk("s6_data",   {24'b0, tx_data}, 32'd0);
        rst = 1'b0;
        tick();
        chk("s6_no_done_idle", {28'b0, done}, 32'd0);
        chk("s6_idle", {31'b0, busy}, 32'd0);
        pready = 1'b0;

        // Step 3: all requests held, eight frames rotate 0,1,2,3,0,1,2,3
        data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req  = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            wait_grant(cyc);
            exp_g = 4'b0001 << (f % 4);
            chk("s3_grant", {28'b0, grant}, {28'b0, exp_g});
            chk("s3_data",  {24'b0, tx_data}, 32'hA0 + 32'h11 * (f % 4));
            chk("s3_latency", cyc, (f == 0) ? 32'd1 : 32'd3);
            finish_frame(4'b1111, exp_g);
        end
        req = 4'b0000;
        tick(); tick();
        chk("s3_idle", {31'b0, busy}, 32'd0);

`ifdef USRT_ARB_TIMEOUT_EN
        // Step 5: no completion, watchdog fires after 16 BUSY cycles
        req = 4'b0011;
        wait_grant(cyc);
        chk("s5_grant", {28'b0, grant}, 32'b0001);
        req = 4'b0010;
        tick();
        chk("s5_enable", {31'b0, tx_en}, 32'd1);
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (timeout || (done != 4'b0)) early = 1'b1;
        end
        chk("s5_no_early", {31'b0, early}, 32'd0);
        tick();
        chk("s5_timeout", {31'b0, timeout}, 32'd1);
        chk("s5_no_done", {28'b0, done}, 32'd0);
        wait_grant(cyc);
        chk("s5_gap_cycles", cyc, 32'd3);
        chk("s5_next_grant", {28'b0, grant}, 32'b0010);
        finish_frame(4'b0000, 4'b0010);
        tick(); tick();
        chk("s5_idle", {31'b0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
